// File: rtl/cardinal_nic.sv
// Network interface between a processing element and one pe port pair of the ring router.
// Define NIC_POLARITY_CHECK_EN to gate injection on net_polarity matching the packet VC bit.
module cardinal_nic #(
    parameter int PACKET_SIZE = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             addr,
    input  logic [PACKET_SIZE-1:0] d_in,
    output logic [PACKET_SIZE-1:0] d_out,
    input  logic                   nicEn,
    input  logic                   nicWrEn,
    input  logic                   net_si,
    output logic                   net_ri,
    input  logic [PACKET_SIZE-1:0] net_di,
    output logic                   net_so,
    input  logic                   net_ro,
    output logic [PACKET_SIZE-1:0] net_do,
    input  logic                   net_polarity
);

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    logic [PACKET_SIZE-1:0] in_buf_reg,  in_buf_next;
    logic [PACKET_SIZE-1:0] out_buf_reg, out_buf_next;
    logic [PACKET_SIZE-1:0] d_out_reg,   d_out_next;
    logic                   in_full_reg,  in_full_next;
    logic                   out_full_reg, out_full_next;

    logic pe_rd;
    logic pe_wr;
    logic rx_accept;
    logic polarity_ok;

    assign pe_rd     = nicEn & ~nicWrEn;
    assign pe_wr     = nicEn & nicWrEn;
    assign net_ri    = ~in_full_reg;
    assign rx_accept = net_si & ~in_full_reg;

`ifdef NIC_POLARITY_CHECK_EN
    // A packet may only enter the ring on the cycle matching its virtual channel.
    assign polarity_ok = (net_polarity == out_buf_reg[PACKET_SIZE-1]);
`else
    logic unused_polarity;
    assign unused_polarity = net_polarity;
    assign polarity_ok     = 1'b1;
`endif

    assign net_so = out_full_reg & net_ro & polarity_ok;
    assign net_do = out_buf_reg;
    assign d_out  = d_out_reg;

    always_comb begin
        in_buf_next   = in_buf_reg;
        in_full_next  = in_full_reg;
        out_buf_next  = out_buf_reg;
        out_full_next = out_full_reg;
        d_out_next    = d_out_reg;

        // Fill and PE drain of the input buffer are exclusive: a fill needs it empty.
        if (rx_accept) begin
            in_buf_next  = net_di;
            in_full_next = 1'b1;
        end else if (pe_rd && addr == ADDR_IN_BUF && in_full_reg) begin
            in_full_next = 1'b0;
        end

        if (pe_rd) begin
            case (addr)
                ADDR_IN_BUF:   d_out_next = in_buf_reg;
                ADDR_IN_STAT:  d_out_next = {{(PACKET_SIZE-1){1'b0}}, in_full_reg};
                ADDR_OUT_STAT: d_out_next = {{(PACKET_SIZE-1){1'b0}}, out_full_reg};
                default:       d_out_next = d_out_reg;
            endcase
        end

        // A write landing while the buffer is still full (even if draining now) is dropped.
        if (net_so) begin
            out_full_next = 1'b0;
        end else if (pe_wr && addr == ADDR_OUT_BUF && !out_full_reg) begin
            out_buf_next  = d_in;
            out_full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_buf_reg   <= '0;
            out_buf_reg  <= '0;
            d_out_reg    <= '0;
            in_full_reg  <= 1'b0;
            out_full_reg <= 1'b0;
        end else begin
            in_buf_reg   <= in_buf_next;
            out_buf_reg  <= out_buf_next;
            d_out_reg    <= d_out_next;
            in_full_reg  <= in_full_next;
            out_full_reg <= out_full_next;
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios then randomized traffic
// compared against a queue-based model of the two single-packet channels.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    cardinal_nic #(.PACKET_SIZE(64)) dut (
        .clk(clk), .reset(reset), .addr(addr), .d_in(d_in), .d_out(d_out),
        .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
        .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
        .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: each channel is a queue holding at most one packet.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] m_last_rx;
    logic [63:0] m_last_tx;
    logic [63:0] m_dout;
    logic [63:0] dut_sent[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic model_so();
        logic ok;
        ok = (out_q.size() != 0) && net_ro;
`ifdef NIC_POLARITY_CHECK_EN
        if (out_q.size() != 0) ok = ok && (net_polarity == out_q[0][63]);
`endif
        return ok;
    endfunction

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_last_rx = '0;
        m_last_tx = '0;
        m_dout    = '0;
    endtask

    // One clock: compare outputs at the falling edge, then apply the edge to the model.
    task automatic tick();
        logic        exp_ri, exp_so, rd, wr_ok, rx;
        logic [63:0] nd;
        @(negedge clk);
        exp_ri = (in_q.size() == 0);
        exp_so = model_so();
        check("net_ri", {63'b0, net_ri}, {63'b0, exp_ri});
        check("net_so", {63'b0, net_so}, {63'b0, exp_so});
        check("net_do", net_do, (out_q.size() != 0) ? out_q[0] : m_last_tx);
        check("d_out", d_out, m_dout);
        if (net_so === 1'b1) dut_sent.push_back(net_do);

        rd    = nicEn && !nicWrEn;
        wr_ok = nicEn && nicWrEn && addr == 2'b10 && out_q.size() == 0;
        rx    = net_si && exp_ri;
        nd    = m_dout;
        if (rd) begin
            case (addr)
                2'b00: nd = m_last_rx;
                2'b01: nd = 64'(in_q.size());
                2'b11: nd = 64'(out_q.size());
                default: nd = m_dout;
            endcase
        end
        if (rd && addr == 2'b00 && in_q.size() != 0) void'(in_q.pop_front());
        if (rx) begin
            in_q.push_back(net_di);
            m_last_rx = net_di;
        end
        if (exp_so) void'(out_q.pop_front());
        else if (wr_ok) begin
            out_q.push_back(d_in);
            m_last_tx = d_in;
        end
        m_dout = nd;
        if (reset) model_reset();
        if (rd || (nicEn && nicWrEn) || rx || exp_so || reset)
            $display("cyc %0d rst=%0b en=%0b wr=%0b addr=%0d rx=%0b so=%0b pol=%0b d_out_next=%h",
                     cyc, reset, nicEn, nicWrEn, addr, rx, exp_so, net_polarity, nd);
        @(posedge clk);
        #1;
        cyc++;
        net_polarity = ~net_polarity;
    endtask

    task automatic pe_read(input logic [1:0] a);
        nicEn = 1'b1; nicWrEn = 1'b0; addr = a;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic pe_write(input logic [63:0] v);
        nicEn = 1'b1; nicWrEn = 1'b1; addr = 2'b10; d_in = v;
        tick();
        nicEn = 1'b0; nicWrEn = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;

        // Reset state and empty status
        tick();
        check("rst_ri", {63'b0, net_ri}, 64'd1);
        check("rst_so", {63'b0, net_so}, 64'd0);
        check("rst_dout", d_out, 64'd0);
        pe_read(2'b01);
        check("rst_in_stat", d_out, 64'd0);
        pe_read(2'b11);
        check("rst_out_stat", d_out, 64'd0);

        // Router to PE
        net_si = 1'b1; net_di = 64'h0000_0300_0000_AAAA;
        tick();
        net_si = 1'b0;
        check("fill_ri", {63'b0, net_ri}, 64'd0);
        pe_read(2'b01);
        check("fill_stat", d_out, 64'd1);
        pe_read(2'b00);
        check("fill_data", d_out, 64'h0000_0300_0000_AAAA);
        check("drain_ri", {63'b0, net_ri}, 64'd1);

        // PE to router, VC=1
        net_ro = 1'b1;
        base = dut_sent.size();
        pe_write(64'h8000_0000_0000_1234);
        repeat (4) tick();
        check("vc1_sent_cnt", 64'(dut_sent.size() - base), 64'd1);
        if (dut_sent.size() > base) check("vc1_sent_data", dut_sent[base], 64'h8000_0000_0000_1234);
        pe_read(2'b11);
        check("vc1_out_stat", d_out, 64'd0);

        // Write while full is dropped
        net_ro = 1'b0;
        base = dut_sent.size();
        pe_write(64'h0000_0000_0000_0777);
        pe_write(64'h0000_0000_0000_5555);
        pe_read(2'b11);
        check("full_stat", d_out, 64'd1);
        net_ro = 1'b1;
        repeat (4) tick();
        check("drop_sent_cnt", 64'(dut_sent.size() - base), 64'd1);
        if (dut_sent.size() > base) check("drop_sent_data", dut_sent[base], 64'h0000_0000_0000_0777);

        // Input buffer held while the router keeps offering
        net_si = 1'b1; net_di = 64'h1111_2222_3333_4444;
        tick();
        net_di = 64'h9999_8888_7777_6666;
        repeat (3) tick();
        check("hold_ri", {63'b0, net_ri}, 64'd0);
        net_si = 1'b0;
        pe_read(2'b00);
        check("hold_data", d_out, 64'h1111_2222_3333_4444);

        // Reset with both buffers full
        net_ro = 1'b0;
        pe_write(64'h0123_4567_89AB_CDEF);
        net_si = 1'b1; net_di = 64'hDEAD_BEEF_0000_0001;
        tick();
        net_si = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        net_ro = 1'b1;
        check("rst2_ri", {63'b0, net_ri}, 64'd1);
        check("rst2_so", {63'b0, net_so}, 64'd0);
        check("rst2_dout", d_out, 64'd0);
        pe_read(2'b01);
        check("rst2_in_stat", d_out, 64'd0);
        pe_read(2'b11);
        check("rst2_out_stat", d_out, 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 63) == 0);
            nicEn   = ($urandom_range(0, 1) == 1);
            nicWrEn = ($urandom_range(0, 2) == 0);
            addr    = 2'($urandom_range(0, 3));
            d_in    = {$urandom, $urandom};
            net_si  = ($urandom_range(0, 2) == 0);
            net_di  = {$urandom, $urandom};
            net_ro  = ($urandom_range(0, 3) != 0);
            tick();
        end
        reset = 1'b0; nicEn = 1'b0; net_si = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cardinal_nic.md
# cardinal_nic

Network interface controller between a processing element (PE) and the `pe*` port pair of the bidirectional ring router.
- Exposes a 4-entry register map to the PE: input channel buffer, input status, output channel buffer, output status.
- Moves single 64-bit packets to and from the router with the ring's send/ready handshake.
- Injection is gated by the router's even/odd `polarity` so a packet enters only on its virtual channel.

## Interface
- `PACKET_SIZE`, 64: packet width. Bit 63 = virtual-channel (VC) bit, bit 62 = direction (0 cw, 1 ccw), bits 55:48 = hop count. The NIC passes all of these through untouched.
- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-high.
- `addr` input 2: register select. 00 = input buffer (R), 01 = input status (R), 10 = output buffer (W), 11 = output status (R).
- `d_in` input PACKET_SIZE: PE write data.
- `d_out` output PACKET_SIZE: registered PE read data.
- `nicEn` input 1: PE access enable.
- `nicWrEn` input 1: 1 = write, 0 = read; qualified by `nicEn`.
- `net_si` input 1: router offers a packet to the NIC (router `peso`).
- `net_ri` output 1: NIC can accept (router `pero`).
- `net_di` input PACKET_SIZE: packet from router (router `pedo`).
- `net_so` output 1: NIC sends a packet (router `pesi`).
- `net_ro` input 1: router can accept (router `peri`).
- `net_do` output PACKET_SIZE: packet to router (router `pedi`).
- `net_polarity` input 1: router polarity; 0 even, 1 odd; toggles every cycle.

## Operation
- State:
  - `in_buf[63:0]` with `in_full` flag (input channel buffer).
  - `out_buf[63:0]` with `out_full` flag (output channel buffer).
  - `d_out` register.
- Reset: `in_full`=0, `out_full`=0, `in_buf`=0, `out_buf`=0, `d_out`=0. Consequently `net_ri`=1, `net_so`=0, `net_do`=0.
- Input channel:
  - `net_ri` = ~`in_full` (combinational).
  - On an edge with `net_si`&`net_ri`: `in_buf`<=`net_di`, `in_full`<=1.
- PE read (`nicEn`=1, `nicWrEn`=0): `d_out` loads next edge.
  - addr 00: `d_out`<=`in_buf`. If `in_full`, `in_full`<=0; an empty read returns stale data and changes no state.
  - addr 01: `d_out`<={63'b0,`in_full`}.
  - addr 11: `d_out`<={63'b0,`out_full`}.
  - addr 10: `d_out` holds.
- PE write (`nicEn`=1, `nicWrEn`=1, addr 10): if `out_full`=0, `out_buf`<=`d_in` and `out_full`<=1. A write while full is dropped silently. Writes to other addresses are ignored.
- `d_out` holds its value when `nicEn`=0 or on any write.
- Output channel:
  - `net_do` = `out_buf` (continuous).
  - `net_so` = `out_full` & `net_ro` & (`net_polarity` == `out_buf[63]`) when the check is compiled in (see Configuration).
  - When `net_so`=1 at an edge: `out_full`<=0.
- Simultaneous events:
  - Router write and PE read of addr 00 in one cycle cannot both take effect: a router write needs `in_full`=0, and the read clears nothing when empty.
  - Drain and PE write of addr 10 in one cycle: the write is dropped because `out_full` was 1; the drain clears the flag.
  - A PE status read in the same cycle as a fill or drain returns the pre-edge flag.
- Reset asserted mid-operation discards any buffered packet. No partial state survives.

## Timing
- PE read latency: 1 cycle. Data is on `d_out` after the edge that samples the request.
- PE write to `net_so` high: minimum 1 cycle. Additional wait until `net_ro`=1 and the polarity matches, at most 1 extra cycle for the polarity alone.
- Router to PE: `in_full` is visible in status the cycle after capture. Input-path throughput is 1 packet per 2 cycles (fill, then PE read).
- `net_ri` and `net_so` are combinational from registered state and inputs, with no combinational path from `net_si` to `net_ri`.

## Configuration
- `NIC_POLARITY_CHECK_EN` defined: injection is gated by `net_polarity` == `out_buf[63]` as above.
- Undefined: `net_so` = `out_full` & `net_ro`, ignoring polarity. Used for standalone PE-loopback testing only.

## Test plan
- Reset for 3 cycles, then idle -> `net_ri`=1, `net_so`=0, `d_out`=0. Status reads at addr 01 and 11 return 0.
- `net_si`=1 with `net_di`=64'h0000_0300_0000_AAAA -> next cycle `net_ri`=0 and status 01 = 1. Read addr 00 -> `d_out`=64'h0000_0300_0000_AAAA, then `net_ri`=1 again.
- Write addr 10 with `d_in`=64'h8000_0000_0000_1234 (VC=1), `net_ro`=1, polarity toggling -> `net_so` is high only in a cycle with `net_polarity`=1, `net_do` matches `d_in`, and status 11 = 0 afterwards.
- Fill the output buffer with `net_ro`=0, then write 64'h5555 -> the second write is dropped. Raise `net_ro` -> the first packet is sent and 64'h5555 never appears.
- Buffer full with `net_si`=1 held for 3 cycles -> `net_ri` stays 0 and `in_buf` is unchanged until the PE read.
- Assert `reset` while both buffers are full -> next cycle both flags are 0, `net_so`=0, `net_ri`=1.
